// File: rtl/mem_access_if.sv
// Data-memory stage bundle: instruction/operand inputs, memory bus, and the
// result/stall signals returned to the core.
interface mem_access_if;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] load_data;
    logic        load_valid;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    modport slave (
        input  opcode, funct3, addr, wdata, mem_rdata, mem_ready,
        output mem_addr, mem_wdata, mem_be, mem_rd, mem_wr,
               load_data, load_valid, stall, misalign, bus_err
    );

    modport master (
        output opcode, funct3, addr, wdata, mem_rdata, mem_ready,
        input  mem_addr, mem_wdata, mem_be, mem_rd, mem_wr,
               load_data, load_valid, stall, misalign, bus_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage: drives the data-memory bus, stalls the core until a
// variable-latency memory answers, and returns extended load data.
//
// state  | meaning
// IDLE   | decode incoming instruction, launch bus access or flag error
// ACCESS | strobe held, waiting for mem_ready or timeout
// DONE   | access complete, core advances for one cycle
// ERR    | misaligned/illegal/timeout, instruction retires without effect
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    mem_access_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_e;

    localparam logic [6:0]      OP_LOAD  = 7'b0000011;
    localparam logic [6:0]      OP_STORE = 7'b0100011;
    localparam logic [TO_W-1:0] TO_CNT   = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] CNT_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

    state_e          state_q;
    logic [TO_W-1:0] cnt_q;
    logic [31:0]     mem_addr_q, mem_wdata_q, load_data_q;
    logic [3:0]      mem_be_q;
    logic            mem_rd_q, mem_wr_q, misalign_q, bus_err_q;
    logic            is_load_q, uns_q;
    logic [1:0]      size_q, off_q;

    logic        is_load, is_store, is_mem, legal, misal;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_ext;

    assign is_load  = (bus.opcode == OP_LOAD);
    assign is_store = (bus.opcode == OP_STORE);
    assign is_mem   = is_load | is_store;

    always_comb begin
        legal = 1'b0;
        if (is_load)
            legal = (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else if (is_store)
            legal = (bus.funct3 inside {3'b000, 3'b001, 3'b010});
        misal = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    end

    // Loads always fetch the full word; lane selection happens on return.
    always_comb begin
        st_be   = 4'b1111;
        st_data = bus.wdata;
        if (is_store) begin
            case (bus.funct3[1:0])
                2'b00: begin
                    st_be   = 4'b0001 << bus.addr[1:0];
                    st_data = {4{bus.wdata[7:0]}};
                end
                2'b01: begin
                    st_be   = 4'b0011 << {bus.addr[1], 1'b0};
                    st_data = {2{bus.wdata[15:0]}};
                end
                default: begin
                    st_be   = 4'b1111;
                    st_data = bus.wdata;
                end
            endcase
        end
    end

    always_comb begin
        case (off_q)
            2'b00:   byte_sel = bus.mem_rdata[7:0];
            2'b01:   byte_sel = bus.mem_rdata[15:8];
            2'b10:   byte_sel = bus.mem_rdata[23:16];
            default: byte_sel = bus.mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (size_q)
            2'b00:   ld_ext = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   ld_ext = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ld_ext = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            load_data_q <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            is_load_q   <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
        end else begin
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (is_mem) begin
                        is_load_q <= is_load;
                        if (!legal) begin
                            bus_err_q <= 1'b1;
                            state_q   <= ERR;
                        end else if (misal) begin
                            misalign_q <= 1'b1;
                            state_q    <= ERR;
                        end else begin
                            mem_addr_q  <= {bus.addr[31:2], 2'b00};
                            mem_be_q    <= st_be;
                            mem_wdata_q <= st_data;
                            mem_rd_q    <= is_load;
                            mem_wr_q    <= is_store;
                            uns_q       <= bus.funct3[2];
                            size_q      <= bus.funct3[1:0];
                            off_q       <= bus.addr[1:0];
                            cnt_q       <= CNT_ONE;
                            state_q     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Completion takes priority over a coincident timeout.
                    if (bus.mem_ready) begin
                        if (is_load_q)
                            load_data_q <= ld_ext;
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= DONE;
                    end else if (cnt_q == TO_CNT) begin
                        mem_rd_q  <= 1'b0;
                        mem_wr_q  <= 1'b0;
                        bus_err_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ERR;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset gating keeps the decode-driven outputs at 0 while rst_ni is low.
    assign bus.stall      = rst_ni & (((state_q == IDLE) & is_mem) | (state_q == ACCESS));
    assign bus.load_valid = rst_ni & (((state_q == IDLE) & ~is_mem) |
                                      ((state_q == DONE) & is_load_q));
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.load_data  = load_data_q;
    assign bus.misalign   = misalign_q;
    assign bus.bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a short timeout so the abort path
// is reachable.
module tb_mem_access_unit;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_NOP   = 7'b0010011;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    int          s_stall, s_rd, s_wr, s_mis, s_err;
    logic [31:0] s_addr, s_wd, s_ld;
    logic [3:0]  s_be;
    logic        s_lv, s_done;

    mem_access_if bus_if ();

    mem_access_unit #(.TIMEOUT(4), .TO_W(8)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus_if)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Entered just after a rising edge with the unit idle; returns just after
    // the edge that leaves DONE/ERR, with a NOP presented.
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int rdy_n);
        int acc;
        acc = 0;
        s_stall = 0; s_rd = 0; s_wr = 0; s_mis = 0; s_err = 0;
        s_addr = '0; s_wd = '0; s_be = '0; s_lv = 1'b0; s_ld = '0; s_done = 1'b0;
        bus_if.opcode = op; bus_if.funct3 = f3; bus_if.addr = a;
        bus_if.wdata = wd; bus_if.mem_rdata = rd;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (bus_if.stall)    s_stall++;
            if (bus_if.mem_rd)   s_rd++;
            if (bus_if.mem_wr)   s_wr++;
            if (bus_if.misalign) s_mis++;
            if (bus_if.bus_err)  s_err++;
            if (bus_if.mem_rd || bus_if.mem_wr) begin
                s_addr = bus_if.mem_addr;
                s_be   = bus_if.mem_be;
                s_wd   = bus_if.mem_wdata;
                acc++;
                if (acc == rdy_n) bus_if.mem_ready = 1'b1;
            end
            if (!bus_if.stall) begin
                s_lv   = bus_if.load_valid;
                s_ld   = bus_if.load_data;
                s_done = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
            bus_if.mem_ready = 1'b0;
        end
        check("op_completes", {31'd0, s_done}, 32'd1);
        @(posedge clk_i); #1;
        bus_if.opcode    = OP_NOP;
        bus_if.mem_ready = 1'b0;
    endtask

    initial begin
        bus_if.opcode = OP_NOP; bus_if.funct3 = '0; bus_if.addr = '0;
        bus_if.wdata = '0; bus_if.mem_rdata = '0; bus_if.mem_ready = 1'b0;
        #2;
        check("rst_mem_rd", {31'd0, bus_if.mem_rd}, 0);
        check("rst_stall", {31'd0, bus_if.stall}, 0);
        check("rst_load_valid", {31'd0, bus_if.load_valid}, 0);
        check("rst_load_data", bus_if.load_data, 0);
        #20 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("nop_stall", {31'd0, bus_if.stall}, 0);
        check("nop_load_valid", {31'd0, bus_if.load_valid}, 1);
        @(posedge clk_i); #1;

        run_op(OP_LOAD, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3);
        check("lw_rd_cycles", s_rd, 3);
        check("lw_stall_cycles", s_stall, 4);
        check("lw_be", {28'd0, s_be}, 32'hF);
        check("lw_addr", s_addr, 32'h100);
        check("lw_data", s_ld, 32'hDEADBEEF);
        check("lw_valid", {31'd0, s_lv}, 1);

        run_op(OP_LOAD, 3'b000, 32'h103, 0, 32'h80123456, 1);
        check("lb_data", s_ld, 32'hFFFFFF80);
        check("lb_stall", s_stall, 2);
        check("lb_addr", s_addr, 32'h100);
        run_op(OP_LOAD, 3'b100, 32'h103, 0, 32'h80123456, 2);
        check("lbu_data", s_ld, 32'h00000080);
        run_op(OP_LOAD, 3'b001, 32'h100, 0, 32'h80128001, 1);
        check("lh_data", s_ld, 32'hFFFF8001);
        run_op(OP_LOAD, 3'b101, 32'h102, 0, 32'h80123456, 1);
        check("lhu_data", s_ld, 32'h00008012);

        run_op(OP_STORE, 3'b000, 32'h201, 32'h000000A5, 0, 3);
        check("sb_addr", s_addr, 32'h200);
        check("sb_be", {28'd0, s_be}, 32'h2);
        check("sb_wdata", s_wd, 32'hA5A5A5A5);
        check("sb_wr_cycles", s_wr, 3);
        check("sb_rd_cycles", s_rd, 0);
        check("sb_valid", {31'd0, s_lv}, 0);
        check("sb_keeps_load_data", s_ld, 32'h00008012);

        run_op(OP_STORE, 3'b001, 32'h202, 32'h1234BEEF, 0, 1);
        check("sh_be", {28'd0, s_be}, 32'hC);
        check("sh_wdata", s_wd, 32'hBEEFBEEF);
        run_op(OP_STORE, 3'b010, 32'h204, 32'h12345678, 0, 1);
        check("sw_be", {28'd0, s_be}, 32'hF);
        check("sw_wdata", s_wd, 32'h12345678);

        run_op(OP_STORE, 3'b010, 32'h202, 32'h1, 0, 1);
        check("sw_mis_wr", s_wr, 0);
        check("sw_mis_pulse", s_mis, 1);
        check("sw_mis_stall", s_stall, 1);
        check("sw_mis_valid", {31'd0, s_lv}, 0);
        run_op(OP_LOAD, 3'b001, 32'h101, 0, 0, 1);
        check("lh_mis_rd", s_rd, 0);
        check("lh_mis_pulse", s_mis, 1);
        check("lh_mis_stall", s_stall, 1);
        check("lh_mis_err", s_err, 0);

        run_op(OP_LOAD, 3'b011, 32'h100, 0, 0, 1);
        check("ill_ld_err", s_err, 1);
        check("ill_ld_rd", s_rd, 0);
        check("ill_ld_mis", s_mis, 0);
        run_op(OP_STORE, 3'b011, 32'h100, 0, 0, 1);
        check("ill_st_err", s_err, 1);
        check("ill_st_wr", s_wr, 0);

        run_op(OP_LOAD, 3'b010, 32'h300, 0, 32'h11111111, 0);
        check("to_rd_cycles", s_rd, 4);
        check("to_stall", s_stall, 5);
        check("to_err_pulse", s_err, 1);
        check("to_valid", {31'd0, s_lv}, 0);
        check("to_keeps_load_data", s_ld, 32'h00008012);
        @(negedge clk_i);
        check("to_err_cleared", {31'd0, bus_if.bus_err}, 0);
        @(posedge clk_i); #1;

        run_op(OP_LOAD, 3'b010, 32'h100, 0, 32'hCAFEF00D, 4);
        check("ready_at_timeout_wins", s_ld, 32'hCAFEF00D);
        check("ready_at_timeout_err", s_err, 0);
        check("ready_at_timeout_valid", {31'd0, s_lv}, 1);

        bus_if.opcode = OP_LOAD; bus_if.funct3 = 3'b010; bus_if.addr = 32'h400;
        repeat (2) @(posedge clk_i);
        #3;
        check("pre_rst_rd", {31'd0, bus_if.mem_rd}, 1);
        rst_ni = 1'b0;
        #1;
        check("async_rst_rd", {31'd0, bus_if.mem_rd}, 0);
        check("async_rst_stall", {31'd0, bus_if.stall}, 0);
        check("async_rst_load_data", bus_if.load_data, 0);
        bus_if.opcode = OP_NOP;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        bus_if.mem_ready = 1'b1;
        @(posedge clk_i); #1;
        bus_if.mem_ready = 1'b0;
        @(negedge clk_i);
        check("late_ready_rd", {31'd0, bus_if.mem_rd}, 0);
        check("late_ready_stall", {31'd0, bus_if.stall}, 0);
        check("late_ready_valid", {31'd0, bus_if.load_valid}, 1);
        check("late_ready_load_data", bus_if.load_data, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
